// File: rtl/psg_bus_regfile_pkg.sv
// Shared types for the PSG bus responder: bus-state encoding, register indices and write masks.
package psg_pkg;

    // Encoding is {BDIR, BC1} with BC2 tied high, as driven by VIA port B.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        LATCH = 2'b11
    } bus_state_e;

    localparam logic [3:0] R_PER_A_LO  = 4'd0;
    localparam logic [3:0] R_PER_A_HI  = 4'd1;
    localparam logic [3:0] R_PER_B_LO  = 4'd2;
    localparam logic [3:0] R_PER_B_HI  = 4'd3;
    localparam logic [3:0] R_PER_C_LO  = 4'd4;
    localparam logic [3:0] R_PER_C_HI  = 4'd5;
    localparam logic [3:0] R_NOISE     = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_AMP_A     = 4'd8;
    localparam logic [3:0] R_AMP_B     = 4'd9;
    localparam logic [3:0] R_AMP_C     = 4'd10;
    localparam logic [3:0] R_ENV_LO    = 4'd11;
    localparam logic [3:0] R_ENV_HI    = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IOA       = 4'd14;
    localparam logic [3:0] R_IOB       = 4'd15;

    // Unimplemented bits are never stored, so readback sees them as zero like a real AY.
    function automatic logic [7:0] psg_reg_mask(input logic [3:0] idx);
        case (idx)
            R_PER_A_HI, R_PER_B_HI, R_PER_C_HI, R_ENV_SHAPE: psg_reg_mask = 8'h0F;
            R_NOISE, R_AMP_A, R_AMP_B, R_AMP_C:              psg_reg_mask = 8'h1F;
            default:                                         psg_reg_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/psg_bus_regfile_if.sv
// VIA-to-PSG port bundle: strobe, chip reset, BC1/BDIR, data bus out and read data back.
interface psg_bus_regfile_if;
    logic       en_clk_psg_i;
    logic       reset_n_i;
    logic       bc_i;
    logic       bdir_i;
    logic [7:0] data_i;
    logic [7:0] data_r_o;

    modport master (
        output en_clk_psg_i, reset_n_i, bc_i, bdir_i, data_i,
        input  data_r_o
    );

    modport slave (
        input  en_clk_psg_i, reset_n_i, bc_i, bdir_i, data_i,
        output data_r_o
    );
endinterface

// File: rtl/psg_bus_regfile.sv
// AY-3-8913 bus decoder and R0-R15 register file for one Mockingboard PSG.
// Optional macro PSG_IO_PORTS_EN adds the R14/R15 I/O port pins.
module psg_bus_regfile
    import psg_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR_HI = 4'h0,
    parameter logic [7:0] READ_IDLE    = 8'hFF
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    psg_bus_regfile_if.slave psg_bus,
`ifdef PSG_IO_PORTS_EN
    input  logic [7:0]  ioa_i,
    input  logic [7:0]  iob_i,
    output logic [7:0]  ioa_o,
    output logic [7:0]  iob_o,
`endif
    output logic [11:0] period_a_o,
    output logic [11:0] period_b_o,
    output logic [11:0] period_c_o,
    output logic [4:0]  noise_period_o,
    output logic [7:0]  mixer_o,
    output logic [4:0]  amp_a_o,
    output logic [4:0]  amp_b_o,
    output logic [4:0]  amp_c_o,
    output logic [15:0] env_period_o,
    output logic [3:0]  env_shape_o,
    output logic        env_restart_o
);

    bus_state_e r_state;
    bus_state_e w_sampled;
    bus_state_e w_state_next;
    logic [3:0] r_addr;
    logic       r_selected;
    logic [7:0] r_regs [16];
    logic [7:0] r_data_r;
    logic       r_env_restart;
    logic       w_latch_fire;
    logic       w_write_fire;
    logic [7:0] w_rd_data;

    // Actions fire only on the strobe where the sampled state differs from the held one,
    // so a WRITE held across many strobes writes once.
    always_comb begin
        w_sampled    = bus_state_e'({psg_bus.bdir_i, psg_bus.bc_i});
        w_state_next = r_state;
        w_latch_fire = 1'b0;
        w_write_fire = 1'b0;
        if (psg_bus.en_clk_psg_i) begin
            w_state_next = w_sampled;
            if (w_sampled != r_state) begin
                w_latch_fire = (w_sampled == LATCH);
                w_write_fire = (w_sampled == WRITE) && r_selected;
            end
        end
    end

    always_comb begin
        w_rd_data = r_regs[r_addr];
`ifdef PSG_IO_PORTS_EN
        if (r_addr == R_IOA && !r_regs[R_MIXER][6]) w_rd_data = ioa_i;
        if (r_addr == R_IOB && !r_regs[R_MIXER][7]) w_rd_data = iob_i;
`endif
    end

    // NOTE: the register array is reset explicitly because the PSG reset line must
    // clear every register; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_selected    <= 1'b0;
            r_data_r      <= READ_IDLE;
            r_env_restart <= 1'b0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (!psg_bus.reset_n_i) begin
            // Chip reset is level-sensitive on every clock and overrides any bus action.
            r_state       <= IDLE;
            r_addr        <= '0;
            r_selected    <= 1'b0;
            r_data_r      <= READ_IDLE;
            r_env_restart <= 1'b0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            r_state       <= w_state_next;
            r_env_restart <= w_write_fire && (r_addr == R_ENV_SHAPE);
            if (w_latch_fire) begin
                r_addr     <= psg_bus.data_i[3:0];
                r_selected <= (psg_bus.data_i[7:4] == CHIP_ADDR_HI);
            end
            if (w_write_fire) r_regs[r_addr] <= psg_bus.data_i & psg_reg_mask(r_addr);
            if (psg_bus.en_clk_psg_i)
                r_data_r <= (w_sampled == READ && r_selected) ? w_rd_data : READ_IDLE;
        end
    end

    assign psg_bus.data_r_o = r_data_r;
    assign env_restart_o    = r_env_restart;

    assign period_a_o     = {r_regs[R_PER_A_HI][3:0], r_regs[R_PER_A_LO]};
    assign period_b_o     = {r_regs[R_PER_B_HI][3:0], r_regs[R_PER_B_LO]};
    assign period_c_o     = {r_regs[R_PER_C_HI][3:0], r_regs[R_PER_C_LO]};
    assign noise_period_o = r_regs[R_NOISE][4:0];
    assign mixer_o        = r_regs[R_MIXER];
    assign amp_a_o        = r_regs[R_AMP_A][4:0];
    assign amp_b_o        = r_regs[R_AMP_B][4:0];
    assign amp_c_o        = r_regs[R_AMP_C][4:0];
    assign env_period_o   = {r_regs[R_ENV_HI], r_regs[R_ENV_LO]};
    assign env_shape_o    = r_regs[R_ENV_SHAPE][3:0];

`ifdef PSG_IO_PORTS_EN
    assign ioa_o = r_regs[R_MIXER][6] ? r_regs[R_IOA] : 8'hFF;
    assign iob_o = r_regs[R_MIXER][7] ? r_regs[R_IOB] : 8'hFF;
`endif

endmodule

// File: tb/tb_psg_bus_regfile.sv
// Scoreboard bench for psg_bus_regfile: expectations queued with stimulus, compared after the strobe.
module tb_psg_bus_regfile;
    import psg_pkg::*;

    typedef enum {O_DATA_R, O_MIXER, O_PER_A, O_PER_C, O_NOISE, O_AMP_A, O_ENV_PER,
                  O_ENV_SHAPE, O_RESTART_CNT, O_IOA} out_sel_e;

    typedef struct {
        string      tag;
        out_sel_e   sel;
        logic [15:0] exp;
    } sb_item_t;

    logic clk_logic = 1'b0;
    logic system_reset_n = 1'b0;
    logic [11:0] period_a_o, period_b_o, period_c_o;
    logic [4:0]  noise_period_o, amp_a_o, amp_b_o, amp_c_o;
    logic [7:0]  mixer_o;
    logic [15:0] env_period_o;
    logic [3:0]  env_shape_o;
    logic        env_restart_o;
`ifdef PSG_IO_PORTS_EN
    logic [7:0]  ioa_i = 8'h00, iob_i = 8'h00, ioa_o, iob_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int restart_cnt = 0;
    sb_item_t sb_q[$];

    psg_bus_regfile_if bus_if ();

    psg_bus_regfile dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .psg_bus        (bus_if),
`ifdef PSG_IO_PORTS_EN
        .ioa_i          (ioa_i),
        .iob_i          (iob_i),
        .ioa_o          (ioa_o),
        .iob_o          (iob_o),
`endif
        .period_a_o     (period_a_o),
        .period_b_o     (period_b_o),
        .period_c_o     (period_c_o),
        .noise_period_o (noise_period_o),
        .mixer_o        (mixer_o),
        .amp_a_o        (amp_a_o),
        .amp_b_o        (amp_b_o),
        .amp_c_o        (amp_c_o),
        .env_period_o   (env_period_o),
        .env_shape_o    (env_shape_o),
        .env_restart_o  (env_restart_o)
    );

    always #5 clk_logic = ~clk_logic;

    // Pulses are one clock wide, so sampling once per cycle counts pulses.
    always @(posedge clk_logic) begin
        #2;
        if (env_restart_o) restart_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input out_sel_e sel);
        case (sel)
            O_DATA_R:      observe = {8'h00, bus_if.data_r_o};
            O_MIXER:       observe = {8'h00, mixer_o};
            O_PER_A:       observe = {4'h0, period_a_o};
            O_PER_C:       observe = {4'h0, period_c_o};
            O_NOISE:       observe = {11'h000, noise_period_o};
            O_AMP_A:       observe = {11'h000, amp_a_o};
            O_ENV_PER:     observe = env_period_o;
            O_ENV_SHAPE:   observe = {12'h000, env_shape_o};
            O_RESTART_CNT: observe = restart_cnt[15:0];
`ifdef PSG_IO_PORTS_EN
            O_IOA:         observe = {8'h00, ioa_o};
`endif
            default:       observe = 16'hDEAD;
        endcase
    endfunction

    task automatic expect_out(input string tag, input out_sel_e sel, input logic [15:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, observe(it.sel), it.exp);
        end
    endtask

    // One or more strobes with the bus held in the given state; returns on a falling edge.
    task automatic bus(input bus_state_e st, input logic [7:0] d, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_logic);
            {bus_if.bdir_i, bus_if.bc_i} = st;
            bus_if.data_i       = d;
            bus_if.en_clk_psg_i = 1'b1;
            @(negedge clk_logic);
            bus_if.en_clk_psg_i = 1'b0;
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] d);
        bus(LATCH, {4'h0, addr});
        bus(IDLE, 8'h00);
        bus(WRITE, d);
        bus(IDLE, 8'h00);
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        bus(LATCH, {4'h0, addr});
        bus(IDLE, 8'h00);
        expect_out(tag, O_DATA_R, {8'h00, exp});
        bus(READ, 8'h00);
        drain();
        bus(IDLE, 8'h00);
    endtask

    initial begin
        int base;
        bus_if.en_clk_psg_i = 1'b0;
        bus_if.reset_n_i    = 1'b1;
        bus_if.bc_i         = 1'b0;
        bus_if.bdir_i       = 1'b0;
        bus_if.data_i       = 8'h00;
        repeat (3) @(negedge clk_logic);
        system_reset_n = 1'b1;
        @(negedge clk_logic);

        expect_out("rst_data_r", O_DATA_R, 16'h00FF);
        expect_out("rst_mixer", O_MIXER, 16'h0000);
        expect_out("rst_per_a", O_PER_A, 16'h0000);
        expect_out("rst_restart", O_RESTART_CNT, 16'd0);
        drain();

        // Mixer write and readback, then idle releases the bus.
        bus(LATCH, 8'h07); bus(IDLE, 8'h00);
        expect_out("t1_mixer", O_MIXER, 16'h0038);
        bus(WRITE, 8'h38);
        drain();
        bus(IDLE, 8'h00);
        expect_out("t1_read", O_DATA_R, 16'h0038);
        bus(READ, 8'h00);
        drain();
        expect_out("t1_idle", O_DATA_R, 16'h00FF);
        bus(IDLE, 8'h00);
        drain();

        // Coarse-period mask and direct LATCH->WRITE transition.
        bus(LATCH, 8'h01);
        expect_out("t2_per_a_hi", O_PER_A, 16'h0F00);
        bus(WRITE, 8'hFF);
        drain();
        bus(IDLE, 8'h00);
        rd("t2_read_r1", 4'd1, 8'h0F);
        wr(4'd0, 8'h34);
        expect_out("t2_per_a", O_PER_A, 16'h0F34);
        wr(4'd5, 8'hFF);
        wr(4'd4, 8'h12);
        expect_out("t2_per_c", O_PER_C, 16'h0F12);
        wr(4'd6, 8'hFF);
        expect_out("t2_noise", O_NOISE, 16'h001F);
        wr(4'd11, 8'hAB);
        wr(4'd12, 8'hCD);
        expect_out("t2_env_per", O_ENV_PER, 16'hCDAB);
        drain();
        rd("t2_read_r6", 4'd6, 8'h1F);

        // Chip-select mismatch: writes ignored, reads idle.
        bus(LATCH, 8'h17); bus(IDLE, 8'h00);
        expect_out("t3_mixer_kept", O_MIXER, 16'h0038);
        expect_out("t3_wr_data_r", O_DATA_R, 16'h00FF);
        bus(WRITE, 8'h55);
        drain();
        bus(IDLE, 8'h00);
        expect_out("t3_read_unsel", O_DATA_R, 16'h00FF);
        bus(READ, 8'h00);
        drain();
        bus(IDLE, 8'h00);
        rd("t3_reselect", 4'd7, 8'h38);

        // Envelope shape: held WRITE gives one write and one restart pulse.
        base = restart_cnt;
        bus(LATCH, 8'h0D); bus(IDLE, 8'h00);
        bus(WRITE, 8'h0E, 5);
        bus(IDLE, 8'h00);
        expect_out("t4_shape", O_ENV_SHAPE, 16'h000E);
        expect_out("t4_one_pulse", O_RESTART_CNT, 16'(base + 1));
        drain();
        bus(WRITE, 8'h0E);
        bus(IDLE, 8'h00);
        expect_out("t4_second_pulse", O_RESTART_CNT, 16'(base + 2));
        drain();

        // Chip reset during a WRITE to R8.
        wr(4'd8, 8'h15);
        expect_out("t5_amp_pre", O_AMP_A, 16'h0015);
        drain();
        bus(LATCH, 8'h08); bus(IDLE, 8'h00);
        bus_if.reset_n_i = 1'b0;
        expect_out("t5_amp_rst", O_AMP_A, 16'h0000);
        expect_out("t5_mixer_rst", O_MIXER, 16'h0000);
        bus(WRITE, 8'h1F);
        drain();
        bus_if.reset_n_i = 1'b1;
        bus(WRITE, 8'h1F, 2);
        bus(IDLE, 8'h00);
        expect_out("t5_no_write", O_AMP_A, 16'h0000);
        drain();
        wr(4'd8, 8'hFF);
        expect_out("t5_rewrite", O_AMP_A, 16'h001F);
        drain();

        // Level-sensitive chip reset with no strobe.
        wr(4'd7, 8'h38);
        @(negedge clk_logic); bus_if.reset_n_i = 1'b0;
        @(negedge clk_logic); bus_if.reset_n_i = 1'b1;
        expect_out("t5_level_rst", O_MIXER, 16'h0000);
        drain();

        // Reset suppresses the envelope restart.
        base = restart_cnt;
        bus(LATCH, 8'h0D); bus(IDLE, 8'h00);
        bus_if.reset_n_i = 1'b0;
        bus(WRITE, 8'h0E);
        bus_if.reset_n_i = 1'b1;
        bus(IDLE, 8'h00);
        expect_out("t5_no_restart", O_RESTART_CNT, 16'(base));
        expect_out("t5_shape_clr", O_ENV_SHAPE, 16'h0000);
        drain();

        // Asynchronous system reset between clock edges.
        wr(4'd7, 8'h38);
        bus(LATCH, 8'h07); bus(IDLE, 8'h00);
        expect_out("t5_read_pre", O_DATA_R, 16'h0038);
        bus(READ, 8'h00);
        drain();
        @(posedge clk_logic);
        #3 system_reset_n = 1'b0;
        #1;
        expect_out("t5_async_mixer", O_MIXER, 16'h0000);
        expect_out("t5_async_data_r", O_DATA_R, 16'h00FF);
        drain();
        @(negedge clk_logic); system_reset_n = 1'b1;
        bus(IDLE, 8'h00);

`ifdef PSG_IO_PORTS_EN
        wr(4'd7, 8'h40);
        wr(4'd14, 8'hA5);
        expect_out("t6_ioa_out", O_IOA, 16'h00A5);
        drain();
        wr(4'd7, 8'h00);
        ioa_i = 8'h3C;
        iob_i = 8'h5A;
        rd("t6_ioa_in", 4'd14, 8'h3C);
        rd("t6_iob_in", 4'd15, 8'h5A);
        expect_out("t6_ioa_hiz", O_IOA, 16'h00FF);
        drain();
`else
        wr(4'd14, 8'hA5);
        rd("t6_r14_store", 4'd14, 8'hA5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
